// File: rtl/bullet_pkg.sv
// bullet_pkg: shared definitions for the bullet pool.
//   - default geometry (slot count, x/y widths)
//   - slot width SW and field offsets ACTIVE_BIT / X_LSB / Y_LSB for the defaults
//   - width-generic offset helpers for parameterised instances
//   - slot_t struct plus pack/unpack/make helpers for default-width slots
// Slot layout, MSB to LSB: {active, x, y}.
package bullet_pkg;

    localparam int DEF_NUM_BULLETS = 32;
    localparam int DEF_X_WIDTH     = 12;
    localparam int DEF_Y_WIDTH     = 11;

    localparam int SW         = 1 + DEF_X_WIDTH + DEF_Y_WIDTH;
    localparam int ACTIVE_BIT = SW - 1;
    localparam int X_LSB      = DEF_Y_WIDTH;
    localparam int Y_LSB      = 0;

    // Offset helpers for instances whose widths differ from the defaults.
    function automatic int slot_width(input int xw, input int yw);
        return 1 + xw + yw;
    endfunction

    function automatic int active_bit(input int xw, input int yw);
        return xw + yw;
    endfunction

    function automatic int x_lsb(input int yw);
        return yw;
    endfunction

    typedef struct packed {
        logic                   active;
        logic [DEF_X_WIDTH-1:0] x;
        logic [DEF_Y_WIDTH-1:0] y;
    } slot_t;

    function automatic logic [SW-1:0] pack_slot(input slot_t s);
        return s;
    endfunction

    function automatic slot_t unpack_slot(input logic [SW-1:0] bits);
        return slot_t'(bits);
    endfunction

    function automatic slot_t make_slot(input logic [DEF_X_WIDTH-1:0] x,
                                        input logic [DEF_Y_WIDTH-1:0] y);
        slot_t s;
        s.active = 1'b1;
        s.x      = x;
        s.y      = y;
        return s;
    endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// bullet_pool_if: spawn request channel into the bullet pool.
//   spawn_valid  request to launch a bullet this cycle
//   spawn_x/y    launch position
//   spawn_ready  pool has at least one free slot (combinational from pool state)
//   spawn_drop   spawn_valid while spawn_ready=0
// Handshake: a spawn is accepted on a rising edge where spawn_valid and
// spawn_ready are both high. spawn_ready does not depend on spawn_valid.
// A request seen while spawn_ready=0 is discarded (flagged by spawn_drop),
// not held; the requester re-asserts if it still wants the bullet.
interface bullet_pool_if #(
    parameter int X_WIDTH = 12,
    parameter int Y_WIDTH = 11
);
    logic               spawn_valid;
    logic [X_WIDTH-1:0] spawn_x;
    logic [Y_WIDTH-1:0] spawn_y;
    logic               spawn_ready;
    logic               spawn_drop;

    modport master (
        output spawn_valid, spawn_x, spawn_y,
        input  spawn_ready, spawn_drop
    );

    modport slave (
        input  spawn_valid, spawn_x, spawn_y,
        output spawn_ready, spawn_drop
    );
endinterface

// File: rtl/bullet_slot_alloc.sv
// bullet_slot_alloc: lowest-index priority encoder for free slots.
//   inactive  in   one bit per slot, 1 = slot free
//   grant     out  one-hot, lowest-index free slot (all zero if none)
//   any_free  out  at least one slot is free
module bullet_slot_alloc #(
    parameter int N = 32
) (
    input  logic [N-1:0] inactive,
    output logic [N-1:0] grant,
    output logic         any_free
);
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (inactive[k] && !found) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any_free = |inactive;
endmodule

// File: rtl/bullet_pool.sv
// bullet_pool: fixed pool of bullet slots that spawn, move on a periodic
// tick, retire when leaving the screen and can be killed by hit logic.
//   clock         system clock, all state on rising edge
//   reset         synchronous, active-high
//   spawn         bullet_pool_if.slave spawn channel
//   kill_mask     bit k clears slot k at next edge
//   bullets       packed slots, slot k at [k*SW +: SW], {active, x, y}
//   active_count  popcount of active bits
//   tick          registered one-cycle movement pulse every TICK_DIV cycles
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS = 32,
    parameter int X_WIDTH     = 12,
    parameter int Y_WIDTH     = 11,
    parameter int SPEED       = 2,
    parameter int TICK_DIV    = 524288,
    parameter int DIR_UP      = 1,
    parameter int Y_MAX       = 767
) (
    input  logic                                        clock,
    input  logic                                        reset,
    bullet_pool_if.slave                                spawn,
    input  logic [NUM_BULLETS-1:0]                      kill_mask,
    output logic [NUM_BULLETS*(1+X_WIDTH+Y_WIDTH)-1:0]  bullets,
    output logic [$clog2(NUM_BULLETS+1)-1:0]            active_count,
    output logic                                        tick
);
    localparam int SWL   = slot_width(X_WIDTH, Y_WIDTH);
    localparam int AB    = active_bit(X_WIDTH, Y_WIDTH);
    localparam int CW    = $clog2(NUM_BULLETS + 1);
    localparam int TCW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // y arithmetic runs one bit wider so overflow past Y_MAX is visible.
    localparam logic [Y_WIDTH:0]  SPEED_W = (Y_WIDTH+1)'(SPEED);
    localparam logic [Y_WIDTH:0]  YMAX_W  = (Y_WIDTH+1)'(Y_MAX);
    localparam logic [TCW-1:0]    TC_LAST = TCW'(TICK_DIV - 1);

    logic [NUM_BULLETS*SWL-1:0] slots_q;
    logic [NUM_BULLETS*SWL-1:0] slots_d;
    logic [NUM_BULLETS-1:0]     active;
    logic [NUM_BULLETS-1:0]     grant;
    logic                       any_free;
    logic                       spawn_fire;
    logic [TCW-1:0]             tick_cnt;

    // ---------------- tick generator ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (tick_cnt == TC_LAST) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            tick     <= 1'b0;
        end
    end

    // ---------------- allocation ----------------
    always_comb begin
        active = '0;
        for (int k = 0; k < NUM_BULLETS; k++) begin
            active[k] = slots_q[k*SWL + AB];
        end
    end

    bullet_slot_alloc #(.N(NUM_BULLETS)) u_alloc (
        .inactive (~active),
        .grant    (grant),
        .any_free (any_free)
    );

    assign spawn.spawn_ready = any_free;
    assign spawn.spawn_drop  = spawn.spawn_valid & ~any_free;
    assign spawn_fire        = spawn.spawn_valid & any_free;

    // ---------------- slot next state ----------------
    // Priority per slot: spawn into a free slot, then kill, then movement.
    // A spawn only targets an inactive slot, so kill on that slot is moot and
    // the fresh bullet never moves on its load edge. Slots freed this cycle
    // are still active in slots_q, so they cannot be granted until next cycle.
    always_comb begin
        logic [SWL-1:0]   cur;
        logic [SWL-1:0]   nxt;
        logic [Y_WIDTH:0] y_ext;
        logic [Y_WIDTH:0] y_new;
        slots_d = '0;
        for (int k = 0; k < NUM_BULLETS; k++) begin
            cur   = slots_q[k*SWL +: SWL];
            nxt   = cur;
            y_ext = {1'b0, cur[Y_WIDTH-1:0]};
            y_new = '0;
            if (spawn_fire && grant[k]) begin
                nxt = {1'b1, spawn.spawn_x, spawn.spawn_y};
            end else if (!cur[AB] || kill_mask[k]) begin
                nxt = '0;
            end else if (tick) begin
                if (DIR_UP != 0) begin
                    if (y_ext < SPEED_W) begin
                        nxt = '0;
                    end else begin
                        y_new = y_ext - SPEED_W;
                        nxt[Y_WIDTH-1:0] = y_new[Y_WIDTH-1:0];
                    end
                end else begin
                    y_new = y_ext + SPEED_W;
                    if (y_new > YMAX_W) begin
                        nxt = '0;
                    end else begin
                        nxt[Y_WIDTH-1:0] = y_new[Y_WIDTH-1:0];
                    end
                end
            end
            slots_d[k*SWL +: SWL] = nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slots_q <= '0;
        end else begin
            slots_q <= slots_d;
        end
    end

    assign bullets = slots_q;

    // ---------------- active count ----------------
    always_comb begin
        active_count = '0;
        for (int k = 0; k < NUM_BULLETS; k++) begin
            active_count = active_count + CW'(active[k]);
        end
    end
endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: directed bench for bullet_pool.
// u_up: NUM_BULLETS=4, SPEED=2, TICK_DIV=4, DIR_UP=1.
// u_dn: same but DIR_UP=0, Y_MAX=767.
module tb_bullet_pool;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  kill_up = '0;
    logic [3:0]  kill_dn = '0;
    logic [95:0] bul_up, bul_dn;
    logic [2:0]  cnt_up, cnt_dn;
    logic        tick_up, tick_dn;

    int ncmp  = 0;
    int nfail = 0;

    bullet_pool_if #(.X_WIDTH(12), .Y_WIDTH(11)) sif_up ();
    bullet_pool_if #(.X_WIDTH(12), .Y_WIDTH(11)) sif_dn ();

    bullet_pool #(.NUM_BULLETS(4), .X_WIDTH(12), .Y_WIDTH(11), .SPEED(2),
                  .TICK_DIV(4), .DIR_UP(1), .Y_MAX(767)) u_up (
        .clock(clock), .reset(reset), .spawn(sif_up.slave), .kill_mask(kill_up),
        .bullets(bul_up), .active_count(cnt_up), .tick(tick_up)
    );

    bullet_pool #(.NUM_BULLETS(4), .X_WIDTH(12), .Y_WIDTH(11), .SPEED(2),
                  .TICK_DIV(4), .DIR_UP(0), .Y_MAX(767)) u_dn (
        .clock(clock), .reset(reset), .spawn(sif_dn.slave), .kill_mask(kill_dn),
        .bullets(bul_dn), .active_count(cnt_dn), .tick(tick_dn)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required summary before limit");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [23:0] mk(input logic a, input logic [11:0] x, input logic [10:0] y);
        return {a, x, y};
    endfunction

    function automatic logic [95:0] pool(input logic [23:0] s0, input logic [23:0] s1,
                                         input logic [23:0] s2, input logic [23:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic clk1();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk1();
        reset = 1'b0;
    endtask

    task automatic spawn_up(input logic v, input logic [11:0] x, input logic [10:0] y);
        sif_up.spawn_valid = v;
        sif_up.spawn_x     = x;
        sif_up.spawn_y     = y;
    endtask

    task automatic spawn_dn(input logic v, input logic [11:0] x, input logic [10:0] y);
        sif_dn.spawn_valid = v;
        sif_dn.spawn_x     = x;
        sif_dn.spawn_y     = y;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        spawn_up(1'b0, '0, '0);
        spawn_dn(1'b0, '0, '0);

        // Single spawn then first movement.
        do_reset();
        chk("rst_bullets", bul_up, 96'h0);
        chk("rst_count", cnt_up, 3'd0);
        chk("rst_tick", tick_up, 1'b0);
        chk("rst_ready", sif_up.spawn_ready, 1'b1);
        spawn_up(1'b1, 12'd100, 11'd10);
        #1;
        chk("t1_drop", sif_up.spawn_drop, 1'b0);
        clk1();
        spawn_up(1'b0, '0, '0);
        chk("t1_spawn", bul_up, pool(mk(1, 100, 10), 0, 0, 0));
        chk("t1_count", cnt_up, 3'd1);
        clk1();
        clk1();
        chk("t1_tick_lo", tick_up, 1'b0);
        clk1();
        chk("t1_tick_hi", tick_up, 1'b1);
        chk("t1_premove", bul_up, pool(mk(1, 100, 10), 0, 0, 0));
        clk1();
        chk("t1_moved", bul_up, pool(mk(1, 100, 8), 0, 0, 0));
        chk("t1_tick_off", tick_up, 1'b0);
        chk("t1_count2", cnt_up, 3'd1);

        // Fill all slots, then drop.
        do_reset();
        spawn_up(1'b1, 12'd200, 11'd100); clk1();
        spawn_up(1'b1, 12'd201, 11'd110); clk1();
        spawn_up(1'b1, 12'd202, 11'd120); clk1();
        spawn_up(1'b1, 12'd203, 11'd130); clk1();
        chk("t2_full", bul_up, pool(mk(1, 200, 100), mk(1, 201, 110), mk(1, 202, 120), mk(1, 203, 130)));
        chk("t2_count", cnt_up, 3'd4);
        spawn_up(1'b1, 12'd204, 11'd140);
        #1;
        chk("t2_ready", sif_up.spawn_ready, 1'b0);
        chk("t2_drop", sif_up.spawn_drop, 1'b1);
        clk1();
        chk("t2_moved", bul_up, pool(mk(1, 200, 98), mk(1, 201, 108), mk(1, 202, 118), mk(1, 203, 128)));
        chk("t2_drop2", sif_up.spawn_drop, 1'b1);
        clk1();
        chk("t2_hold", bul_up, pool(mk(1, 200, 98), mk(1, 201, 108), mk(1, 202, 118), mk(1, 203, 128)));
        spawn_up(1'b0, '0, '0);

        // Top-edge retirement: y=1 clears, y=2 reaches 0 then clears.
        do_reset();
        spawn_up(1'b1, 12'd5, 11'd1); clk1();
        spawn_up(1'b1, 12'd6, 11'd2); clk1();
        spawn_up(1'b0, '0, '0);
        clk1();
        clk1();
        clk1();
        chk("t3_first", bul_up, pool(0, mk(1, 6, 0), 0, 0));
        chk("t3_count", cnt_up, 3'd1);
        chk("t3_ready", sif_up.spawn_ready, 1'b1);
        clk1(); clk1(); clk1();
        chk("t3_hold0", bul_up, pool(0, mk(1, 6, 0), 0, 0));
        clk1();
        chk("t3_gone", bul_up, 96'h0);
        chk("t3_count0", cnt_up, 3'd0);

        // Kill with spawn on a full pool, then spawn into the freed slot.
        do_reset();
        spawn_up(1'b1, 12'd1, 11'd400); clk1();
        spawn_up(1'b1, 12'd2, 11'd410); clk1();
        spawn_up(1'b1, 12'd3, 11'd420); clk1();
        spawn_up(1'b1, 12'd4, 11'd430); clk1();
        kill_up = 4'b0010;
        spawn_up(1'b1, 12'd77, 11'd300);
        #1;
        chk("t4_drop", sif_up.spawn_drop, 1'b1);
        clk1();
        chk("t4_killed", bul_up, pool(mk(1, 1, 398), 0, mk(1, 3, 418), mk(1, 4, 428)));
        chk("t4_count", cnt_up, 3'd3);
        chk("t4_ready", sif_up.spawn_ready, 1'b1);
        clk1();
        kill_up = 4'b0000;
        spawn_up(1'b0, '0, '0);
        chk("t4_respawn", bul_up, pool(mk(1, 1, 398), mk(1, 77, 300), mk(1, 3, 418), mk(1, 4, 428)));
        chk("t4_count4", cnt_up, 3'd4);

        // Downward pool: bottom edge and spawn coinciding with tick.
        do_reset();
        spawn_dn(1'b1, 12'd9, 11'd765); clk1();
        spawn_dn(1'b0, '0, '0);
        clk1(); clk1(); clk1();
        chk("t5_tick", tick_dn, 1'b1);
        spawn_dn(1'b1, 12'd10, 11'd50); clk1();
        spawn_dn(1'b0, '0, '0);
        chk("t5_move", bul_dn, pool(mk(1, 9, 767), mk(1, 10, 50), 0, 0));
        clk1(); clk1(); clk1();
        chk("t5_hold", bul_dn, pool(mk(1, 9, 767), mk(1, 10, 50), 0, 0));
        clk1();
        chk("t5_edge", bul_dn, pool(0, mk(1, 10, 52), 0, 0));
        chk("t5_count", cnt_dn, 3'd1);

        // Reset mid-flight with a tick about to fire.
        do_reset();
        spawn_up(1'b1, 12'd11, 11'd500); clk1();
        spawn_up(1'b1, 12'd12, 11'd501); clk1();
        spawn_up(1'b1, 12'd13, 11'd502); clk1();
        chk("t6_count3", cnt_up, 3'd3);
        reset = 1'b1;
        clk1();
        reset = 1'b0;
        spawn_up(1'b0, '0, '0);
        chk("t6_bullets", bul_up, 96'h0);
        chk("t6_count", cnt_up, 3'd0);
        chk("t6_ready", sif_up.spawn_ready, 1'b1);
        chk("t6_tick0", tick_up, 1'b0);
        clk1(); chk("t6_tick1", tick_up, 1'b0);
        clk1(); chk("t6_tick2", tick_up, 1'b0);
        clk1(); chk("t6_tick3", tick_up, 1'b0);
        clk1(); chk("t6_tick4", tick_up, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
